// File: rtl/syn_fifo_pkg.sv
// Shared sizing helpers and output-mode constants for the syn_fifo family.
package syn_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointer index width for a given depth (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: one extra bit so the value DEPTH itself is representable.
    function automatic int count_width(input int depth);
        return addr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/syn_fifo_mem.sv
// WIDTH x DEPTH storage array: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module syn_fifo_mem
    import syn_fifo_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the accepted word into its slot.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, registered
// threshold flags, sticky error flags and the read-data output path
// (registered standard mode or first-word-fall-through).
module syn_fifo_ctrl
    import syn_fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_MODE_STD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          write_en,
    input  logic                          read_en,
    input  logic                          err_clr,
    output logic [WIDTH-1:0]              data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int ADDR_W = addr_width(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    // Parameter legality, caught at elaboration.
    if (WIDTH < 1) begin : g_bad_width
        $error("syn_fifo_ctrl: WIDTH must be >= 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("syn_fifo_ctrl: DEPTH must be a power of 2 and >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("syn_fifo_ctrl: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("syn_fifo_ctrl: AE_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("syn_fifo_ctrl: FWFT must be 0 or 1");
    end

    // Pointers carry one extra MSB so they simply wrap with the counter width.
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [CNT_W-1:0] count_nxt;
    logic [WIDTH-1:0] rdata;

    // Accepts use the registered flags, so a write while full never
    // displaces a concurrent read and a read while empty is ignored.
    assign wr_acc = write_en & ~full;
    assign rd_acc = read_en & ~empty;

    // Next occupancy: flags are derived from this so they move with count.
    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc)      count_nxt = count + CNT_W'(1);
        else if (rd_acc && !wr_acc) count_nxt = count - CNT_W'(1);
    end

    // Pointers, count and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            if (rd_acc) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
        end
    end

    // Sticky error flags; a new error on the same edge beats err_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (write_en & full)  | (overflow  & ~err_clr);
            underflow <= (read_en  & empty) | (underflow & ~err_clr);
        end
    end

    syn_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word shows through directly; forced to zero while empty so
        // the output is deterministic out of reset.
        assign data_out = empty ? '0 : rdata;
    end else begin : g_std
        // Registered read: head word captured on the accepting edge.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)        data_out <= '0;
            else if (rd_acc) data_out <= rdata;
        end
    end

endmodule
